dev_reshuffler_csr_master: RTL and testbench

//   Initiator side of the dev-reshuffler CSR req/rsp interface. Buffers CSR commands
//   {addr, data, we} from a host/testbench stream in a small FIFO. Issues them one at a

---
 rtl/dev_reshuffler_csr_master.sv | 175 +++++++++++++++++
 tb/tb_dev_reshuffler_csr_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_reshuffler_csr_master.sv
// CSR req/rsp initiator: queues {addr, data, we} commands and issues them one at a time.
// Optional watchdog: define DEV_CSR_MASTER_TIMEOUT_EN.
module dev_reshuffler_csr_master #(
  parameter int unsigned RegCount      = 8,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned RegAddrWidth  = $clog2(RegCount),
  parameter int unsigned CmdDepth      = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [RegAddrWidth-1:0]     cmd_addr_i,
  input  logic [RegDataWidth-1:0]     cmd_wr_data_i,
  input  logic                        cmd_wr_en_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  output logic [RegAddrWidth-1:0]     csr_addr_o,
  output logic [RegDataWidth-1:0]     csr_wr_data_o,
  output logic                        csr_wr_en_o,
  output logic                        csr_req_valid_o,
  input  logic                        csr_req_ready_i,
  input  logic [RegDataWidth-1:0]     csr_rd_data_i,
  input  logic                        csr_rsp_valid_i,
  output logic                        csr_rsp_ready_o,
  output logic [RegDataWidth-1:0]     rd_data_o,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic                        busy_o,
  output logic [$clog2(CmdDepth):0]   cmd_count_o,
  output logic                        timeout_err_o
);

  localparam int unsigned PtrWidth   = $clog2(CmdDepth);
  localparam int unsigned CntWidth   = PtrWidth + 1;
  localparam int unsigned EntryWidth = RegAddrWidth + RegDataWidth + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_OUT} state_e;

  state_e                   state_reg;
  logic [EntryWidth-1:0]    fifo_mem [CmdDepth];
  logic [PtrWidth-1:0]      wr_ptr_reg;
  logic [PtrWidth-1:0]      rd_ptr_reg;
  logic [CntWidth-1:0]      count_reg;
  logic [RegAddrWidth-1:0]  csr_addr_reg;
  logic [RegDataWidth-1:0]  csr_wr_data_reg;
  logic                     csr_wr_en_reg;
  logic                     req_valid_reg;
  logic [RegDataWidth-1:0]  rd_data_reg;
  logic                     rd_valid_reg;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     tmo_fire;

  assign fifo_full  = (count_reg == CntWidth'(CmdDepth));
  assign fifo_empty = (count_reg == '0);
  // Ready looks only at full, so a pop in the same cycle never frees a slot early.
  assign push       = cmd_valid_i && !fifo_full;
  assign pop        = (state_reg == ST_IDLE) && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_addr_i, cmd_wr_data_i, cmd_wr_en_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrWidth'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrWidth'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CntWidth'(1);
        2'b01:   count_reg <= count_reg - CntWidth'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef DEV_CSR_MASTER_TIMEOUT_EN
  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

  logic [TmoWidth-1:0] tmo_cnt_reg;
  logic                tmo_err_reg;
  logic                stalled;

  assign stalled  = ((state_reg == ST_REQ) && !csr_req_ready_i) ||
                    ((state_reg == ST_RSP) && !csr_rsp_valid_i);
  assign tmo_fire = stalled && (tmo_cnt_reg == TmoWidth'(TimeoutCycles - 1));

  // Any state change (handshake or timeout) restarts the count from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      if (stalled && !tmo_fire) tmo_cnt_reg <= tmo_cnt_reg + TmoWidth'(1);
      else                      tmo_cnt_reg <= '0;
      if (tmo_fire) tmo_err_reg <= 1'b1;
    end
  end

  assign timeout_err_o = tmo_err_reg;
`else
  assign tmo_fire      = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      csr_addr_reg    <= '0;
      csr_wr_data_reg <= '0;
      csr_wr_en_reg   <= 1'b0;
      req_valid_reg   <= 1'b0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {csr_addr_reg, csr_wr_data_reg, csr_wr_en_reg} <= fifo_mem[rd_ptr_reg];
            req_valid_reg <= 1'b1;
            state_reg     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (csr_req_ready_i) begin
            req_valid_reg <= 1'b0;
            state_reg     <= ST_RSP;
          end else if (tmo_fire) begin
            req_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        ST_RSP: begin
          if (csr_rsp_valid_i) begin
            if (csr_wr_en_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              rd_data_reg  <= csr_rd_data_i;
              rd_valid_reg <= 1'b1;
              state_reg    <= ST_OUT;
            end
          end else if (tmo_fire) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (rd_ready_i) begin
            rd_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = !fifo_full;
  assign csr_addr_o      = csr_addr_reg;
  assign csr_wr_data_o   = csr_wr_data_reg;
  assign csr_wr_en_o     = csr_wr_en_reg;
  assign csr_req_valid_o = req_valid_reg;
  assign csr_rsp_ready_o = (state_reg == ST_RSP);
  assign rd_data_o       = rd_data_reg;
  assign rd_valid_o      = rd_valid_reg;
  assign busy_o          = (state_reg != ST_IDLE) || !fifo_empty;
  assign cmd_count_o     = count_reg;

endmodule

// File: tb/tb_dev_reshuffler_csr_master.sv
// Bench for dev_reshuffler_csr_master: queue-based reference model, responder with a register file,
// directed scenarios plus a randomized run.
module tb_dev_reshuffler_csr_master;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TMO = 16;
`ifdef DEV_CSR_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_wr_data_i = '0;
  logic          cmd_wr_en_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] csr_addr_o;
  logic [DW-1:0] csr_wr_data_o;
  logic          csr_wr_en_o;
  logic          csr_req_valid_o;
  logic          csr_req_ready_i = 1'b0;
  logic [DW-1:0] csr_rd_data_i = '0;
  logic          csr_rsp_valid_i = 1'b0;
  logic          csr_rsp_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic          busy_o;
  logic [2:0]    cmd_count_o;
  logic          timeout_err_o;

  dev_reshuffler_csr_master #(
    .RegCount(8), .RegDataWidth(DW), .CmdDepth(DEPTH), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_addr_i(cmd_addr_i), .cmd_wr_data_i(cmd_wr_data_i), .cmd_wr_en_i(cmd_wr_en_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .csr_addr_o(csr_addr_o), .csr_wr_data_o(csr_wr_data_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_rd_data_i(csr_rd_data_i), .csr_rsp_valid_i(csr_rsp_valid_i),
    .csr_rsp_ready_o(csr_rsp_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .cmd_count_o(cmd_count_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queued commands, the command in flight, and which phase it is in
  // (0 none, 1 requesting, 2 awaiting response, 3 presenting read data).
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } cmd_t;

  cmd_t          m_q[$];
  cmd_t          m_cur = '0;
  int            m_phase = 0;
  logic [DW-1:0] m_rd = '0;
  bit            m_err = 1'b0;
  int            m_wait = 0;
  cmd_t          m_new;
  bit            m_push;
  int            m_prev;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_q.delete();
        m_phase = 0;
        m_rd    = '0;
        m_err   = 1'b0;
        m_wait  = 0;
      end else begin
        m_push = cmd_valid_i && (m_q.size() < DEPTH);
        m_new  = {cmd_addr_i, cmd_wr_data_i, cmd_wr_en_i};
        m_prev = m_phase;
        case (m_phase)
          0: if (m_q.size() > 0) begin
               m_cur   = m_q.pop_front();
               m_phase = 1;
             end
          1: if (csr_req_ready_i) m_phase = 2;
             else if (TMO_EN && m_wait == TMO - 1) begin m_phase = 0; m_err = 1'b1; end
             else m_wait++;
          2: if (csr_rsp_valid_i) begin
               if (m_cur.we) begin
                 $display("TXN write addr=%0d data=0x%08h", m_cur.addr, m_cur.data);
                 m_phase = 0;
               end else begin
                 m_rd    = csr_rd_data_i;
                 m_phase = 3;
               end
             end
             else if (TMO_EN && m_wait == TMO - 1) begin m_phase = 0; m_err = 1'b1; end
             else m_wait++;
          default: if (rd_ready_i) begin
               $display("TXN read  addr=%0d data=0x%08h", m_cur.addr, m_rd);
               m_phase = 0;
             end
        endcase
        if (m_phase != m_prev) m_wait = 0;
        if (m_push) m_q.push_back(m_new);
      end
    end
  end

  // Responder: register file, programmable ready/latency, spurious rsp_valid when idle.
  int            rr_mode = 1;       // 0 random, 1 always ready, 2 never ready
  bit            rsp_hold = 1'b0;
  bit            pend = 1'b0;
  int            pdly = 0;
  int            stall_cnt = 0;
  logic [DW-1:0] pdata = '0;
  logic [DW-1:0] reg_file [8];
  logic [DW-1:0] exp_rd[$];

  initial begin
    for (int i = 0; i < 8; i++) reg_file[i] = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        pend = 1'b0;
        exp_rd.delete();
        csr_req_ready_i = 1'b0;
        csr_rsp_valid_i = 1'b0;
        stall_cnt = 0;
      end else begin
        if (pend && !rsp_hold) begin
          if (pdly == 0) begin
            csr_rsp_valid_i = 1'b1;
            csr_rd_data_i   = pdata;
            pend            = 1'b0;
          end else begin
            pdly--;
            csr_rsp_valid_i = 1'b0;
          end
        end else if (!pend && rr_mode == 0) begin
          csr_rsp_valid_i = ($urandom_range(0, 3) == 0);
          csr_rd_data_i   = $urandom;
        end else begin
          csr_rsp_valid_i = 1'b0;
        end
        case (rr_mode)
          0:       csr_req_ready_i = (stall_cnt >= 4) || ($urandom_range(0, 1) == 1);
          1:       csr_req_ready_i = 1'b1;
          default: csr_req_ready_i = 1'b0;
        endcase
        if (csr_req_valid_o && csr_req_ready_i) begin
          pend = 1'b1;
          pdly = (rr_mode == 0) ? $urandom_range(0, 2) : 0;
          if (csr_wr_en_o) reg_file[csr_addr_o] = csr_wr_data_o;
          pdata = reg_file[csr_addr_o];
          if (!csr_wr_en_o) exp_rd.push_back(pdata);
          stall_cnt = 0;
        end else if (csr_req_valid_o) begin
          stall_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus read-data scoreboard.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk_i);
      check("cmd_ready", cmd_ready_o, m_q.size() < DEPTH);
      check("cmd_count", cmd_count_o, m_q.size());
      check("busy", busy_o, (m_phase != 0) || (m_q.size() != 0));
      check("req_valid", csr_req_valid_o, m_phase == 1);
      if (m_phase == 1) begin
        check("req_addr", csr_addr_o, m_cur.addr);
        check("req_data", csr_wr_data_o, m_cur.data);
        check("req_we", csr_wr_en_o, m_cur.we);
      end
      check("rsp_ready", csr_rsp_ready_o, m_phase == 2);
      check("rd_valid", rd_valid_o, m_phase == 3);
      check("rd_data", rd_data_o, m_rd);
      check("timeout_err", timeout_err_o, m_err);
      if (rst_ni && rd_valid_o && rd_ready_i) begin
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 'x;
        check("rd_scoreboard", rd_data_o, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    cmd_addr_i = a; cmd_wr_data_i = d; cmd_wr_en_i = w; cmd_valid_i = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready_o; i++) tick();
    check("push_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy_o; i++) tick();
    check("drain_idle", busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check({tag, "_outs"}, {csr_req_valid_o, csr_rsp_ready_o, rd_valid_o, busy_o, timeout_err_o}, 0);
    check({tag, "_count"}, cmd_count_o, 0);
    check({tag, "_req_fields"}, {csr_addr_o, csr_wr_data_o, csr_wr_en_o}, 0);
    check({tag, "_rd_data"}, rd_data_o, 0);
  endtask

  initial begin
    int acc;
    int n_rdv;
    int n;
    logic [DW-1:0] seen;
    #1 rst_ni = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // Single write: request appears one cycle after the push edge, no read result.
    rr_mode = 1;
    cmd_addr_i = 0; cmd_wr_data_i = 32'h1; cmd_wr_en_i = 1'b1; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    check("w1_count", cmd_count_o, 1);
    check("w1_req_early", csr_req_valid_o, 0);
    tick();
    check("w1_req", {csr_req_valid_o, csr_addr_o, csr_wr_data_o, csr_wr_en_o}, {1'b1, 3'd0, 32'h1, 1'b1});
    n_rdv = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_valid_o) n_rdv++;
      tick();
    end
    check("w1_no_rd", n_rdv, 0);
    check("w1_regfile", reg_file[0], 32'h1);

    // Write then read back.
    rd_ready_i = 1'b1;
    push(3, 32'hDEADBEEF, 1'b1);
    push(3, 32'h0, 1'b0);
    n_rdv = 0; seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid_o) begin n_rdv++; seen = rd_data_o; end
      tick();
    end
    check("rb_count", n_rdv, 1);
    check("rb_data", seen, 32'hDEADBEEF);

    // Backpressure: responder stalls, six pushes attempted.
    rr_mode = 2;
    acc = 0;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_addr_i = AW'(4 + (i % 4)); cmd_wr_data_i = $urandom; cmd_wr_en_i = $urandom_range(0, 1);
      if (cmd_ready_o) acc++;
      tick();
    end
    cmd_valid_i = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", cmd_ready_o, 0);
    check("bp_count", cmd_count_o, 4);
    check("bp_busy", busy_o, 1);
    rr_mode = 1;
    wait_idle(100);

    // Held read result blocks the queued write.
    rd_ready_i = 1'b0;
    push(3, 32'h0, 1'b0);
    push(5, 32'hCAFE0005, 1'b1);
    for (int i = 0; i < 30 && !rd_valid_o; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_rd_valid", rd_valid_o, 1);
      check("hold_rd_data", rd_data_o, 32'hDEADBEEF);
      check("hold_no_req", csr_req_valid_o, 0);
      tick();
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 10 && !csr_req_valid_o; i++) tick();
    check("hold_next_req", {csr_req_valid_o, csr_addr_o, csr_wr_data_o}, {1'b1, 3'd5, 32'hCAFE0005});
    wait_idle(50);

    // Reset while a response is pending with two commands queued.
    rsp_hold = 1'b1;
    push(1, 32'h11, 1'b1);
    push(2, 32'h22, 1'b1);
    push(4, 32'h44, 1'b1);
    for (int i = 0; i < 20 && !csr_rsp_ready_o; i++) tick();
    check("mid_rsp_state", csr_rsp_ready_o, 1);
    check("mid_count", cmd_count_o, 2);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    rst_ni = 1'b1;
    rsp_hold = 1'b0;
    tick();
    push(0, 32'h5A5A, 1'b1);
    tick();
    check("post_rst_req", {csr_req_valid_o, csr_addr_o, csr_wr_data_o, csr_wr_en_o}, {1'b1, 3'd0, 32'h5A5A, 1'b1});
    wait_idle(50);

`ifdef DEV_CSR_MASTER_TIMEOUT_EN
    rr_mode = 2;
    push(2, 32'h77, 1'b1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (csr_req_valid_o) n++;
      else if (n > 0) break;
      tick();
    end
    check("tmo_req_cycles", n, TMO);
    check("tmo_err", timeout_err_o, 1);
    rr_mode = 1;
    push(6, 32'h99, 1'b1);
    tick();
    check("tmo_next_req", {csr_req_valid_o, csr_addr_o}, {1'b1, 3'd6});
    wait_idle(50);
`else
    n = 0;
    check("tmo_err_tied", timeout_err_o, n);
`endif

    // Randomized traffic against the model.
    rr_mode = 0;
    for (int i = 0; i < 400; i++) begin
      cmd_valid_i   = $urandom_range(0, 1);
      cmd_addr_i    = AW'($urandom_range(0, 7));
      cmd_wr_data_i = $urandom;
      cmd_wr_en_i   = $urandom_range(0, 1);
      rd_ready_i    = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid_i = 1'b0;
    rd_ready_i  = 1'b1;
    wait_idle(300);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
